fir_mac: RTL and testbench



---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_mac_if.sv | 19 +
 rtl/fir_delay_line.sv | 31 +++
 rtl/fir_mac.sv | 86 ++++++++
 tb/tb_fir_mac.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, typedefs and the coefficient ROM for the
// 16-tap serial FIR datapath.
//   TAPS            number of taps / delay line depth
//   *_DEF           default sample, coefficient and accumulator widths
//   h_coef(k)       coefficient of tap k (symmetric low-pass, sum 256)
package fir_pkg;
  localparam int TAPS       = 16;
  localparam int DIN_W_DEF  = 8;
  localparam int COEF_W_DEF = 8;
  localparam int ACC_W_DEF  = DIN_W_DEF + COEF_W_DEF + 4;

  typedef logic signed [DIN_W_DEF-1:0]            sample_t;
  typedef logic signed [COEF_W_DEF-1:0]           coef_t;
  typedef logic signed [DIN_W_DEF+COEF_W_DEF-1:0] prod_t;
  typedef logic signed [ACC_W_DEF-1:0]            acc_t;

  function automatic coef_t h_coef(input logic [3:0] k);
    case (k)
      4'd0, 4'd15: h_coef = -8'sd1;
      4'd1, 4'd14: h_coef = -8'sd2;
      4'd2, 4'd13: h_coef =  8'sd0;
      4'd3, 4'd12: h_coef =  8'sd6;
      4'd4, 4'd11: h_coef =  8'sd15;
      4'd5, 4'd10: h_coef =  8'sd27;
      4'd6, 4'd9:  h_coef =  8'sd38;
      default:     h_coef =  8'sd45;  // taps 7 and 8
    endcase
  endfunction
endpackage

// File: rtl/fir_mac_if.sv
// fir_mac_if: sequencer-facing bundle of the FIR MAC.
//   in_st/din          new-sample strobe and sample
//   cnt/count_flag     tap index and running flag from the frame counter
//   y/y_valid          filter output and its one-cycle update strobe
// master drives samples and counter state, slave (the datapath) drives y.
interface fir_mac_if #(
  parameter int DIN_W = 8,
  parameter int ACC_W = 20
);
  logic                    in_st;
  logic signed [DIN_W-1:0] din;
  logic [4:0]              cnt;
  logic                    count_flag;
  logic signed [ACC_W-1:0] y;
  logic                    y_valid;

  modport master (output in_st, din, cnt, count_flag, input  y, y_valid);
  modport slave  (input  in_st, din, cnt, count_flag, output y, y_valid);
endinterface

// File: rtl/fir_delay_line.sv
// fir_delay_line: 16-deep sample shift register with a tap-indexed read mux.
//   clk, rst    clock, synchronous active-high reset (clears all samples)
//   shift, din  push din into x[0] and age every sample by one slot
//   rd_idx      tap index k, rd_data = x[k] (combinational)
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DIN_W = DIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift,
  input  logic signed [DIN_W-1:0] din,
  input  logic [3:0]              rd_idx,
  output logic signed [DIN_W-1:0] rd_data
);
  // x_q[0] is the newest sample, x_q[TAPS-1] the oldest
  logic [TAPS-1:0][DIN_W-1:0] x_q, x_d;

  always_comb begin
    x_d = x_q;
    if (shift) x_d = {x_q[TAPS-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) x_q <= '0;
    else     x_q <= x_d;
  end

  assign rd_data = $signed(x_q[rd_idx]);
endmodule

// File: rtl/fir_mac.sv
// fir_mac: serial multiply-accumulate datapath of the 16-tap FIR.
//   clk, rst   clock, synchronous active-high reset
//   bus        fir_mac_if slave: in_st/din sample strobe, cnt/count_flag
//              from the frame counter, y/y_valid filter output
// Pipeline: tap cycle k registers x[k]*h[k]; the product is accumulated one
// edge later; the full sum is latched into y at the end of cnt=17.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = DIN_W + COEF_W + 4
) (
  input  logic      clk,
  input  logic      rst,
  fir_mac_if.slave  bus
);
  localparam int PROD_W = DIN_W + COEF_W;

  logic signed [DIN_W-1:0]  tap_x;
  logic signed [COEF_W-1:0] tap_h;
  logic                     tap_cyc, out_cyc;

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     pv_q, pv_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     y_valid_q, y_valid_d;

  fir_delay_line #(.DIN_W(DIN_W)) u_dl (
    .clk     (clk),
    .rst     (rst),
    .shift   (bus.in_st),
    .din     (bus.din),
    .rd_idx  (bus.cnt[3:0]),
    .rd_data (tap_x)
  );

  assign tap_h   = COEF_W'(h_coef(bus.cnt[3:0]));
  assign tap_cyc = bus.count_flag && !bus.cnt[4];
  assign out_cyc = bus.count_flag && (bus.cnt == 5'd17);

  always_comb begin
    prod_d    = prod_q;
    pv_d      = 1'b0;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (tap_cyc) begin
      prod_d = PROD_W'(tap_x) * PROD_W'(tap_h);
      pv_d   = 1'b1;
    end
    if (pv_q) acc_d = acc_q + ACC_W'(prod_q);
    if (out_cyc) begin
      y_d       = acc_q;
      y_valid_d = 1'b1;
    end
    // a new sample restarts the frame: partial sum and in-flight product
    // are dropped and no output is published from the aborted frame
    if (bus.in_st) begin
      acc_d     = '0;
      pv_d      = 1'b0;
      y_d       = y_q;
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      pv_q      <= 1'b0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      pv_q      <= pv_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_fir_mac.sv
module tb_fir_mac;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst;

  fir_mac_if #(.DIN_W(DW), .ACC_W(AW)) bus ();
  fir_mac #(.DIN_W(DW), .COEF_W(CW), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  int H_TB [16] = '{-1, -2, 0, 6, 15, 27, 38, 45, 45, 38, 27, 15, 6, 0, -2, -1};
  // running sums of H: output after j+1 frames of a constant input
  int PRE  [16] = '{-1, -3, -3, 3, 18, 45, 83, 128, 173, 211, 238, 253, 259, 259, 257, 256};

  // reference model: sample history, counter, expected outputs
  int  hist [16];
  int  cnt_m;
  bit  flag_m;
  int  ey;
  bit  ev;
  bit  model_on;
  int  pulses;

  typedef struct {
    bit    pre_rst;
    int    din;
    int    exp_y;
    string nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dot();
    int s = 0;
    for (int k = 0; k < 16; k++) s += hist[k] * H_TB[k];
    return s;
  endfunction

  // one clock: drive inputs, advance the model, check outputs after the edge
  task automatic tick(input bit st, input int d, input bit r);
    bus.in_st      = st;
    bus.din        = DW'(d);
    bus.cnt        = 5'(cnt_m);
    bus.count_flag = flag_m;
    rst            = r;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 16; k++) hist[k] = 0;
      ey = 0; ev = 0; cnt_m = 0; flag_m = 0; model_on = 1;
    end else begin
      ev = 0;
      if (flag_m && cnt_m == 17 && !st) begin
        ey = dot();
        ev = 1;
      end
      if (st) begin
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        cnt_m = 0; flag_m = 1;
      end else if (flag_m) begin
        if (cnt_m == 31) flag_m = 0;
        cnt_m = (cnt_m + 1) % 32;
      end
    end
    #1;
    if (bus.y_valid) pulses++;
    if (model_on) begin
      chk("y_valid", int'(bus.y_valid), int'(ev));
      chk("y", int'(bus.y), ey);
    end
  endtask

  task automatic frame(input int d, input int gap);
    tick(1'b1, d, 1'b0);
    repeat (gap - 1) tick(1'b0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bus.in_st = 1'b0; bus.din = '0; bus.cnt = '0; bus.count_flag = 1'b0;
    cnt_m = 0; flag_m = 0; ey = 0; ev = 0; model_on = 0; pulses = 0;
    for (int k = 0; k < 16; k++) hist[k] = 0;

    // impulse, DC max, negative extreme
    for (int i = 0; i < 17; i++)
      tbl.push_back('{i == 0, (i == 0) ? 1 : 0, (i < 16) ? H_TB[i] : 0, $sformatf("impulse%0d", i)});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b0, 127, 127 * PRE[i], $sformatf("dc%0d", i)});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{i == 0, -128, -128 * PRE[i], $sformatf("neg%0d", i)});

    repeat (3) tick(1'b0, 0, 1'b1);
    chk("reset_y", int'(bus.y), 0);
    chk("reset_y_valid", int'(bus.y_valid), 0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) tick(1'b0, 0, 1'b1);
      frame(tbl[i].din, 32);
      chk(tbl[i].nm, int'(bus.y), tbl[i].exp_y);
    end

    // reset in the cnt=9 cycle of a DC frame
    tick(1'b0, 0, 1'b1);
    repeat (16) frame(127, 32);
    tick(1'b1, 127, 1'b0);
    repeat (9) tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b1);
    chk("midrst_y", int'(bus.y), 0);
    chk("midrst_y_valid", int'(bus.y_valid), 0);
    frame(5, 32);
    chk("after_rst_y", int'(bus.y), -5);

    // abort: second strobe lands in the cnt=7 cycle
    tick(1'b0, 0, 1'b1);
    pulses = 0;
    tick(1'b1, 10, 1'b0);
    repeat (7) tick(1'b0, 0, 1'b0);
    tick(1'b1, 20, 1'b0);
    repeat (31) tick(1'b0, 0, 1'b0);
    chk("abort_y", int'(bus.y), -40);
    chk("abort_pulses", pulses, 1);

    // back-to-back strobes: both shift, only the last starts a frame
    tick(1'b0, 0, 1'b1);
    pulses = 0;
    tick(1'b1, 3, 1'b0);
    frame(4, 32);
    chk("b2b_y", int'(bus.y), -10);
    chk("b2b_pulses", pulses, 1);

    // reset and strobe together: reset wins, sample is not captured
    tick(1'b1, 99, 1'b1);
    frame(0, 32);
    chk("rst_vs_st_y0", int'(bus.y), 0);
    frame(0, 32);
    chk("rst_vs_st_y1", int'(bus.y), 0);

    // random samples and spacing, checked every cycle by the model
    repeat (60) begin
      int d, gap;
      d   = int'($urandom_range(0, 255)) - 128;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 32;
      frame(d, gap);
    end
    repeat (32) tick(1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
